spi_fnd_display: RTL and testbench
==================================

SPI_FND_DISPLAY -- requirements
Module: spi_fnd_display

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, digit-advance rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port rx_data  input  8  byte received by the SPI slave, valid when rx_done=1.
REQ-006 SHALL have port rx_done  input  1  one-cycle strobe marking a valid rx_data byte.
REQ-007 SHALL have port pair_clr  input  1  one-cycle strobe forcing the next byte to be treated as the high byte.
REQ-008 SHALL have port value_out  output  14  last assembled, saturated binary value.
REQ-009 SHALL have port busy  output  1  BCD conversion in progress.
REQ-010 SHALL have port fnd_com  output  4  digit enables, active-low one-hot, bit0 = ones digit.
REQ-011 SHALL have port fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-012 Byte pairing: first accepted byte = HI, second = LO, then toggle back to HI; raw = {HI[5:0], LO}; HI[7:6] ignored.
REQ-013 pair_clr SHALL reset pairing to HI; if pair_clr and rx_done coincide, that byte SHALL be taken as HI.
REQ-014 On LO acceptance at cycle N, value_out SHALL update at edge N+1 to min(raw, 9999).
REQ-015 Conversion SHALL be sequential shift-add-3 double-dabble, 14 iterations, one per cycle; FSM states IDLE -> LOAD -> SHIFT(x14) -> DONE -> IDLE.
REQ-016 busy SHALL be 1 from cycle N+1 through N+15 inclusive; displayed digits SHALL reflect the new value from cycle N+16.
REQ-017 A new LO arriving while busy SHALL be stored as pending (latest wins, older pending discarded); conversion of pending SHALL start immediately after DONE, busy staying high without a gap.
REQ-018 Displayed BCD register SHALL only change in DONE; partially shifted values SHALL never reach fnd_data.
REQ-019 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-020 fnd_com SHALL be 1110, 1101, 1011, 0111 for index 0..3; fnd_data SHALL be the segment code of that BCD digit; leading zeros displayed.
REQ-021 Segment codes 0..9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex); dp always 1 (off).
REQ-022 fnd_com and fnd_data SHALL be registered and change on the same edge.
REQ-023 rx_done while rst=0 SHALL be ignored.

Reset
REQ-024 While rst=0 at a rising edge: pairing=HI, value_out=0, busy=0, pending cleared, FSM=IDLE, BCD=0000, scan counter=0, index=0.
REQ-025 Reset outputs: fnd_com=1110, fnd_data=C0.
REQ-026 Reset asserted mid-conversion SHALL abort it; the display SHALL show 0000 after release, not the aborted value.

Verification (CLK_HZ=1000, SCAN_HZ=100, SCAN_DIV=10)
REQ-027 Reset, then idle 40 cycles -> fnd_com cycles 1110/1101/1011/0111 every 10 cycles, fnd_data=C0 throughout, busy=0.
REQ-028 rx_done bytes 0x04 then 0xD2 (raw 1234) -> value_out=1234 at N+1, busy high N+1..N+15, digits show 1,2,3,4 (ones=4 -> fnd_data=99 when fnd_com=1110).
REQ-029 Bytes 0x3F,0xFF (raw 16383) -> value_out=9999, all digits fnd_data=90.
REQ-030 Pair 0x00,0x07 then pair 0x00,0x09 with second LO at N+5 -> busy continuous to ~N+31, final display 0009, no intermediate glitch on fnd_data other than 0007.
REQ-031 Byte 0x01, then pair_clr, then 0x00,0x2A -> value_out=42, not 256+0.
REQ-032 rst=0 at N+8 during conversion of 5678 -> busy=0 next edge, display 0000, value_out=0.

Source files
------------

// File: rtl/spi_fnd_display.sv
// Pairs SPI bytes into a 14-bit value, saturates at 9999, converts to BCD by sequential double-dabble
// and scans four active-low 7-segment digits. Display only updates once a conversion is complete.
module spi_fnd_display #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        pair_clr,
  output logic [13:0] value_out,
  output logic        busy,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_q;
  logic          expect_lo_q;
  logic [5:0]    hi_q;
  logic [13:0]   raw_q;
  logic          lo_stb_q;
  logic          pend_q;
  logic [3:0]    cnt_q;
  logic [29:0]   sr_q;
  logic [15:0]   disp_q;
  logic [CW-1:0] scan_q;
  logic [1:0]    idx_q;
  logic [13:0]   value_q;
  logic          busy_q;
  logic [3:0]    com_q;
  logic [7:0]    data_q;

  logic          hi_acc;
  logic          lo_acc;
  logic [13:0]   raw_sat;
  logic [15:0]   disp_d;
  logic          scan_wrap;
  logic [CW-1:0] scan_d;
  logic [1:0]    idx_d;
  logic [3:0]    digit_sel;

  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // pair_clr wins over the pairing phase, so a coinciding byte becomes the high byte
  assign hi_acc  = rx_done && (pair_clr || !expect_lo_q);
  assign lo_acc  = rx_done && !pair_clr && expect_lo_q;
  assign raw_sat = (raw_q > 14'd9999) ? 14'd9999 : raw_q;

  always_comb begin
    disp_d    = (state_q == DONE) ? sr_q[29:14] : disp_q;
    scan_wrap = (scan_q == CW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    digit_sel = disp_d[4*idx_d +: 4];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      expect_lo_q <= 1'b0;
      hi_q        <= '0;
      raw_q       <= '0;
      lo_stb_q    <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      disp_q      <= '0;
      scan_q      <= '0;
      idx_q       <= '0;
      value_q     <= '0;
      busy_q      <= 1'b0;
      com_q       <= 4'b1110;
      data_q      <= 8'hC0;
    end else begin
      if (hi_acc) begin
        hi_q        <= rx_data[5:0];
        expect_lo_q <= 1'b1;
      end else if (pair_clr) begin
        expect_lo_q <= 1'b0;
      end else if (lo_acc) begin
        raw_q       <= {hi_q, rx_data};
        expect_lo_q <= 1'b0;
      end
      lo_stb_q <= lo_acc;
      if (lo_stb_q) value_q <= raw_sat;

      // raw_q doubles as the pending slot: a later LO simply overwrites it
      case (state_q)
        IDLE: if (lo_acc) state_q <= LOAD;
        LOAD: begin
          sr_q    <= {16'd0, raw_sat};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= SHIFT;
          if (lo_acc) pend_q <= 1'b1;
        end
        SHIFT: begin
          sr_q <= dd_step(sr_q);
          if (cnt_q == 4'd13) state_q <= DONE;
          else                cnt_q   <= cnt_q + 4'd1;
          if (lo_acc) pend_q <= 1'b1;
        end
        DONE: begin
          if (pend_q || lo_acc) begin
            state_q <= LOAD;
            pend_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      disp_q <= disp_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      com_q  <= ~(4'b0001 << idx_d);
      data_q <= seg7(digit_sel);
    end
  end

  assign value_out = value_q;
  assign busy      = busy_q;
  assign fnd_com   = com_q;
  assign fnd_data  = data_q;

endmodule

// File: tb/tb_spi_fnd_display.sv
// Scoreboard bench: stimulus pushes the expected converted value, a negedge monitor pops it when busy
// falls and checks value_out plus the scanned digits against a decimal reference model.
module tb_spi_fnd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        pair_clr = 1'b0;
  logic [13:0] value_out;
  logic        busy;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  always #5 clk = ~clk;

  spi_fnd_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .pair_clr(pair_clr),
    .value_out(value_out), .busy(busy), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int cur_disp  = 0;
  bit skip_busy = 1'b0;
  bit rst_s     = 1'b1;
  bit prev_busy = 1'b0;
  int scan_cyc  = 0;
  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input int v, input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic int com_of(input int idx);
    logic [3:0] c;
    c = 4'hF & ~(4'h1 << idx);
    return int'(c);
  endfunction

  function automatic int sat_raw(input int hi, input int lo);
    int raw = (hi % 64) * 256 + lo;
    return (raw > 9999) ? 9999 : raw;
  endfunction

  // cycles since reset release: digit index is floor(cycles/10) mod 4
  always @(posedge clk) begin
    rst_s    <= rst;
    scan_cyc <= rst ? scan_cyc + 1 : 0;
  end

  always @(negedge clk) begin
    int ei;
    if (!rst_s) begin
      exp_q.delete();
      cur_disp  = 0;
      prev_busy = 1'b0;
      check("rst_value", int'(value_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_com", int'(fnd_com), 4'b1110);
      check("rst_seg", int'(fnd_data), 8'hC0);
    end else if (rst) begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          cur_disp = exp_q.pop_front();
          check("value_out", int'(value_out), cur_disp);
        end
      end
      prev_busy = busy;
      ei = (scan_cyc / 10) % 4;
      check("scan_com", int'(fnd_com), com_of(ei));
      if (!busy || !skip_busy)
        check($sformatf("seg_d%0d", ei), int'(fnd_data), int'(seg_tbl[dig(cur_disp, ei)]));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit clr);
    rx_data  = b;
    rx_done  = 1'b1;
    pair_clr = clr;
    @(posedge clk);
    #1;
    rx_done  = 1'b0;
    pair_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    idle(2);
    while (busy && t < 200) begin
      idle(1);
      t++;
    end
    if (t >= 200) check("busy_timeout", 1, 0);
    idle(45);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, fall_k, hi, lo, e;
    idle(5);
    rst = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      check("idle_com", int'(fnd_com), com_of((k / 10) % 4));
      check("idle_seg", int'(fnd_data), 8'hC0);
      check("idle_busy", int'(busy), 0);
    end

    // 1234 with cycle-exact latency checks
    exp_q.push_back(1234);
    send(8'h04, 1'b0);
    send(8'hD2, 1'b0);
    check("load_busy", int'(busy), 0);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      if (k == 1) check("value_n1", int'(value_out), 1234);
      check($sformatf("busy_n%0d", k), int'(busy), (k <= 15) ? 1 : 0);
    end
    wait_idle();

    exp_q.push_back(9999);
    send(8'h3F, 1'b0);
    send(8'hFF, 1'b0);
    wait_idle();

    // dangling HI cleared by a lone pair_clr
    exp_q.push_back(42);
    send(8'h01, 1'b0);
    idle(1);
    pair_clr = 1'b1;
    idle(1);
    pair_clr = 1'b0;
    send(8'h00, 1'b0);
    send(8'h2A, 1'b0);
    wait_idle();

    // pair_clr coinciding with a byte makes that byte the HI
    exp_q.push_back(5);
    send(8'h01, 1'b0);
    send(8'h00, 1'b1);
    send(8'h05, 1'b0);
    wait_idle();

    // second LO lands while busy: one continuous busy window, 7 then 9
    skip_busy = 1'b1;
    exp_q.push_back(9);
    send(8'h00, 1'b0);
    send(8'h07, 1'b0);
    idle(3);
    send(8'h00, 1'b0);
    send(8'h09, 1'b0);
    bad = 0;
    fall_k = 0;
    for (int k = 6; k <= 40; k++) begin
      idle(1);
      if (!busy && fall_k == 0) fall_k = k;
      if (fnd_com == 4'b1110) begin
        if (fnd_data != 8'h92 && fnd_data != 8'hF8 && fnd_data != 8'h90) bad++;
      end else if (fnd_data != 8'hC0) bad++;
    end
    check("pend_busy_end", fall_k, 32);
    check("pend_glitch", bad, 0);
    wait_idle();
    skip_busy = 1'b0;

    for (int i = 0; i < 20; i++) begin
      hi = int'($urandom_range(0, 255));
      lo = int'($urandom_range(0, 255));
      e  = sat_raw(hi, lo);
      exp_q.push_back(e);
      case ($urandom_range(0, 3))
        0: begin
          send(8'($urandom_range(0, 255)), 1'b0);
          pair_clr = 1'b1;
          idle(1);
          pair_clr = 1'b0;
          send(8'(hi), 1'b0);
        end
        1: begin
          send(8'($urandom_range(0, 255)), 1'b0);
          send(8'(hi), 1'b1);
        end
        default: send(8'(hi), 1'b0);
      endcase
      send(8'(lo), 1'b0);
      wait_idle();
    end

    // abort 5678 mid-conversion; a byte during reset must be ignored
    exp_q.push_back(5678);
    send(8'h16, 1'b0);
    send(8'h2E, 1'b0);
    idle(6);
    rst = 1'b0;
    idle(1);
    check("abort_busy", int'(busy), 0);
    check("abort_value", int'(value_out), 0);
    send(8'h01, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(45);
    exp_q.push_back(3);
    send(8'h00, 1'b0);
    send(8'h03, 1'b0);
    wait_idle();
    check("final_value", int'(value_out), 3);
    check("queue_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
